// File: rtl/spi_flash_boot_reader_if.sv
// Request/response port between the boot fetch path (master) and spi_flash_boot_reader (slave).
interface spi_flash_boot_reader_if;
    logic        req_valid;
    logic [23:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/spi_flash_boot_reader.sv
// Single-lane SPI (mode 0) boot reader: wakes the flash with 0xAB, then serves 32-bit reads.
// Define SPI_FAST_READ_EN for opcode 0x0B with 8 dummy clocks after the address.
module spi_flash_boot_reader #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned WAKE_WAIT = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    spi_flash_boot_reader_if.slave        bus,
    output logic                          busy,
    output logic                          flash_csb,
    output logic                          flash_clk,
    output logic                          flash_io0,
    input  logic                          flash_io1
);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] READ_OPCODE = 8'h0B;
`else
    localparam logic [7:0] READ_OPCODE = 8'h03;
`endif
    localparam logic [7:0]  WAKE_OPCODE = 8'hAB;
    localparam logic [7:0]  DIV_LOAD    = 8'(CLK_DIV - 1);
    localparam int unsigned GAP_CYCLES  = 2 * CLK_DIV;
    localparam int unsigned CNT_MAX     = (WAKE_WAIT > GAP_CYCLES) ? WAKE_WAIT : GAP_CYCLES;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_WAKE_CMD,
        S_WAKE_WAIT,
        S_IDLE,
        S_CMD,
        S_ADDR,
`ifdef SPI_FAST_READ_EN
        S_DUMMY,
`endif
        S_DATA,
        S_GAP
    } state_t;

    state_t           state;
    logic [7:0]       div_cnt;
    logic [4:0]       bit_cnt;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      tx_sh;
    logic [31:0]      rx_sh;
    logic [23:0]      addr_aligned;
    logic             sclk_tick;
    logic             sclk_rise;
    logic             sclk_fall;
    logic             last_bit;

    assign addr_aligned = bus.req_addr & 24'hFF_FFFC;
    assign sclk_tick    = !flash_csb && (div_cnt == 8'd0);
    assign sclk_rise    = sclk_tick && !flash_clk;
    assign sclk_fall    = sclk_tick && flash_clk;
    assign last_bit     = sclk_fall && (bit_cnt == 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_WAKE_CMD;
            flash_csb     <= 1'b1;
            flash_clk     <= 1'b0;
            flash_io0     <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            busy          <= 1'b1;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            wait_cnt      <= '0;
            tx_sh         <= '0;
            rx_sh         <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;

            if (!flash_csb)
                div_cnt <= sclk_tick ? DIV_LOAD : div_cnt - 8'd1;

            if (sclk_rise) begin
                flash_clk <= 1'b1;
                if (state == S_DATA)
                    rx_sh <= {rx_sh[30:0], flash_io1};
            end

            // Common falling-edge shift; segment ends below override bit_cnt/io0.
            // tx_sh is empty after cmd+addr, so dummy/data phases shift out zeros.
            if (sclk_fall) begin
                flash_clk <= 1'b0;
                bit_cnt   <= bit_cnt - 5'd1;
                flash_io0 <= tx_sh[31];
                tx_sh     <= {tx_sh[30:0], 1'b0};
            end

            case (state)
                S_WAKE_CMD: begin
                    if (flash_csb) begin
                        flash_csb <= 1'b0;
                        flash_io0 <= WAKE_OPCODE[7];
                        tx_sh     <= {WAKE_OPCODE[6:0], 25'd0};
                        bit_cnt   <= 5'd7;
                        div_cnt   <= DIV_LOAD;
                    end else if (last_bit) begin
                        flash_csb <= 1'b1;
                        flash_io0 <= 1'b0;
                        wait_cnt  <= CNT_W'(WAKE_WAIT - 1);
                        state     <= S_WAKE_WAIT;
                    end
                end

                S_WAKE_WAIT, S_GAP: begin
                    if (wait_cnt == '0) begin
                        state         <= S_IDLE;
                        bus.req_ready <= 1'b1;
                        busy          <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end

                S_IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        busy          <= 1'b1;
                        flash_csb     <= 1'b0;
                        flash_io0     <= READ_OPCODE[7];
                        tx_sh         <= {READ_OPCODE[6:0], addr_aligned, 1'b0};
                        bit_cnt       <= 5'd7;
                        div_cnt       <= DIV_LOAD;
                        state         <= S_CMD;
                    end
                end

                S_CMD: begin
                    if (last_bit) begin
                        bit_cnt <= 5'd23;
                        state   <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (last_bit) begin
                        flash_io0 <= 1'b0;
`ifdef SPI_FAST_READ_EN
                        bit_cnt   <= 5'd7;
                        state     <= S_DUMMY;
`else
                        bit_cnt   <= 5'd31;
                        state     <= S_DATA;
`endif
                    end
                end

`ifdef SPI_FAST_READ_EN
                S_DUMMY: begin
                    if (last_bit) begin
                        flash_io0 <= 1'b0;
                        bit_cnt   <= 5'd31;
                        state     <= S_DATA;
                    end
                end
`endif

                S_DATA: begin
                    if (last_bit) begin
                        flash_csb     <= 1'b1;
                        flash_io0     <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= {rx_sh[7:0], rx_sh[15:8], rx_sh[23:16], rx_sh[31:24]};
                        wait_cnt      <= CNT_W'(GAP_CYCLES);
                        state         <= S_GAP;
                    end
                end

                default: state <= S_WAKE_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_boot_reader.sv
// Randomized self-checking bench for spi_flash_boot_reader with a serial NOR flash model.
module tb_spi_flash_boot_reader;
    localparam int CD = 2;
    localparam int WW = 16;
`ifdef SPI_FAST_READ_EN
    localparam int         NB      = 72;
    localparam logic [7:0] OPC     = 8'h0B;
    localparam int         LAT_LIT = 289;
    localparam int         B2B_LIT = 294;
`else
    localparam int         NB      = 64;
    localparam logic [7:0] OPC     = 8'h03;
    localparam int         LAT_LIT = 257;
    localparam int         B2B_LIT = 262;
`endif
    localparam int HDR = NB - 32;
    localparam int FW  = 2 * CD * 8;
    localparam int FR  = 2 * CD * NB;

    logic clk = 1'b0;
    logic rst;
    logic busy, flash_csb, flash_clk, flash_io0;
    logic flash_io1 = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    spi_flash_boot_reader_if bus ();

    spi_flash_boot_reader #(.CLK_DIV(CD), .WAKE_WAIT(WW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .flash_csb (flash_csb),
        .flash_clk (flash_clk),
        .flash_io0 (flash_io0),
        .flash_io1 (flash_io1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] ^ {a[12:8], a[15:13]} ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [23:0] al;
        al = a & 24'hFF_FFFC;
        return {mem_byte(al + 24'd3), mem_byte(al + 24'd2), mem_byte(al + 24'd1), mem_byte(al)};
    endfunction

    // Flash model: captures command/address on SCLK rises, drives data on SCLK falls.
    logic        fm_csb_q = 1'b1;
    logic        fm_clk_q = 1'b0;
    int          fm_n = 0;
    int          fm_d;
    logic [31:0] fm_cmd = '0;
    logic [7:0]  fm_b;
    always @(negedge clk) begin
        if (fm_csb_q === 1'b1 && flash_csb === 1'b0) begin
            fm_n   = 0;
            fm_cmd = '0;
        end
        if (flash_csb === 1'b0 && flash_clk === 1'b1 && fm_clk_q === 1'b0) begin
            if (fm_n < 32) fm_cmd = {fm_cmd[30:0], flash_io0};
            fm_n++;
        end
        if (flash_csb === 1'b0 && flash_clk === 1'b0 && fm_clk_q === 1'b1) begin
            if (fm_n >= HDR) begin
                fm_d      = fm_n - HDR;
                fm_b      = mem_byte(fm_cmd[23:0] + 24'(fm_d / 8));
                flash_io1 = fm_b[7 - (fm_d % 8)];
            end else begin
                flash_io1 = 1'($urandom_range(0, 1));
            end
        end
        fm_csb_q = flash_csb;
        fm_clk_q = flash_clk;
    end

    // Reference model: expected pins derived from frame start time and bit position.
    typedef enum {M_NONE, M_RST, M_WAKE, M_READ} mmode_t;
    mmode_t      m_mode = M_NONE;
    int          m_start = 0;
    int          k;
    logic [71:0] m_bits = '0;
    logic [31:0] m_word = '0;
    logic [31:0] m_data = '0;
    logic [7:0]  wake_b = 8'hAB;
    logic        e_csb, e_clk, e_io0, e_rdy, e_vld, e_busy, idle;
    logic [23:0] m_al;

    always @(negedge clk) begin
        k = cyc - m_start;
        idle = 1'b0;
        e_csb = 1'b1; e_clk = 1'b0; e_io0 = 1'b0;
        e_rdy = 1'b0; e_vld = 1'b0; e_busy = 1'b1;
        case (m_mode)
            M_WAKE: begin
                if (k >= 1 && k <= FW) begin
                    e_csb = 1'b0;
                    e_clk = ((k - 1) % (2 * CD)) >= CD;
                    e_io0 = wake_b[7 - (k - 1) / (2 * CD)];
                end else if (k >= 1 + FW + WW) begin
                    idle = 1'b1;
                end
            end
            M_READ: begin
                if (k == 0 || k >= FR + 2 * CD + 2) begin
                    idle = 1'b1;
                end else if (k <= FR) begin
                    e_csb = 1'b0;
                    e_clk = ((k - 1) % (2 * CD)) >= CD;
                    e_io0 = m_bits[NB - 1 - (k - 1) / (2 * CD)];
                end else if (k == FR + 1) begin
                    e_vld  = 1'b1;
                    m_data = m_word;
                end
            end
            default: ;
        endcase
        if (idle) begin
            e_rdy  = 1'b1;
            e_busy = 1'b0;
        end

        if (m_mode != M_NONE) begin
            chk("pins{csb,clk,io0,ready,valid,busy}",
                {26'd0, flash_csb, flash_clk, flash_io0, bus.req_ready, bus.rsp_valid, busy},
                {26'd0, e_csb, e_clk, e_io0, e_rdy, e_vld, e_busy});
            chk("rsp_data", bus.rsp_data, m_data);
        end

        if (rst === 1'b1) begin
            m_mode = M_RST;
            m_data = '0;
        end else if (m_mode == M_RST) begin
            m_mode  = M_WAKE;
            m_start = cyc;
        end else if (idle && bus.req_valid === 1'b1) begin
            m_mode  = M_READ;
            m_start = cyc;
            m_al    = bus.req_addr & 24'hFF_FFFC;
            m_bits  = '0;
            m_bits[NB - 1 -: 32] = {OPC, m_al};
            m_word  = exp_word(bus.req_addr);
        end
    end

    // Stimulus helpers: every task returns at posedge+1.
    task automatic wait_ready(output int t);
        logic got;
        got = 1'b0;
        t = 0;
        for (int n = 0; n < 2000 && !got; n++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                got = 1'b1;
                t = cyc;
            end
        end
        chk("req_ready_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp(output int t, output logic [31:0] d);
        logic got;
        got = 1'b0;
        t = 0;
        d = '0;
        for (int n = 0; n < 2000 && !got; n++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                got = 1'b1;
                t = cyc;
                d = bus.rsp_data;
            end
        end
        chk("rsp_valid_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
    endtask

    int          rel, ta, tb2, tr;
    logic [31:0] d;
    logic [23:0] ra;

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        rel = cyc;
        wait_ready(ta);
        chk("wake_to_ready", 32'(ta - rel), 32'd49);

        bus.req_valid = 1'b1; bus.req_addr = 24'h000100;
        wait_ready(ta);
        bus.req_valid = 1'b0;
        wait_rsp(tr, d);
        chk("read_0x100_data", d, 32'h44332211);
        chk("read_0x100_latency", 32'(tr - ta), 32'(LAT_LIT));

        bus.req_valid = 1'b1; bus.req_addr = 24'h000103;
        wait_ready(ta);
        bus.req_valid = 1'b0;
        wait_rsp(tr, d);
        chk("read_0x103_data", d, 32'h44332211);
        chk("read_0x103_latency", 32'(tr - ta), 32'(LAT_LIT));

        bus.req_valid = 1'b1; bus.req_addr = 24'h000000;
        wait_ready(ta);
        bus.req_addr = 24'h000004;
        wait_rsp(tr, d);
        chk("b2b_first_data", d, exp_word(24'h000000));
        wait_ready(tb2);
        bus.req_valid = 1'b0;
        chk("b2b_accept_spacing", 32'(tb2 - ta), 32'(B2B_LIT));
        wait_rsp(tr, d);
        chk("b2b_second_data", d, exp_word(24'h000004));

        bus.req_valid = 1'b1; bus.req_addr = 24'($urandom);
        wait_ready(ta);
        bus.req_valid = 1'b0;
        repeat (109) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rel = cyc;
        @(negedge clk);
        chk("rst_csb", {31'd0, flash_csb}, 32'd1);
        chk("rst_sclk", {31'd0, flash_clk}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk); #1;
        wait_ready(ta);
        chk("rewake_to_ready", 32'(ta - rel - 1), 32'd48);

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            ra = 24'($urandom);
            bus.req_valid = 1'b1; bus.req_addr = ra;
            wait_ready(ta);
            bus.req_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                wait_rsp(tr, d);
                chk("rand_data", d, exp_word(ra));
                chk("rand_latency", 32'(tr - ta), 32'(LAT_LIT));
            end
        end
        repeat (FR + 20) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_flash_boot_reader.md
# spi_flash_boot_reader

Single-lane SPI master that fetches 32-bit words from an external serial NOR flash on behalf of the boot path of the user-project core. It sits between the core's instruction/data fetch port and the chip GPIO pads that drive the flash: CSB, SCLK, MOSI (io0) and MISO (io1). After reset it wakes the flash from deep power-down. It then serves read requests one at a time with the standard 0x03 read command.

## Interface
- CLK_DIV, 2: SCLK half-period in clk cycles; legal range 1..255.
- WAKE_WAIT, 16: clk cycles CSB stays high after the 0xAB wake command, before the first read is accepted.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  read request strobe.
- req_addr  in  24  flash byte address; bits [1:0] ignored, treated as 0.
- req_ready  out  1  high when a request is accepted this cycle.
- rsp_valid  out  1  one-cycle pulse; rsp_data valid.
- rsp_data  out  32  fetched word, little-endian: first byte received is bits [7:0].
- busy  out  1  high whenever CSB is low or the wake/gap wait is running.
- flash_csb  out  1  chip select, active low.
- flash_clk  out  1  SPI clock, mode 0.
- flash_io0  out  1  MOSI.
- flash_io1  in  1  MISO.

## Operation
- States: WAKE_CMD, WAKE_WAIT, IDLE, CMD, ADDR, DUMMY (only with the macro), DATA, GAP.
- Reset values:
  - flash_csb=1, flash_clk=0, flash_io0=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, busy=1.
  - State = WAKE_CMD.
- WAKE_CMD:
  - CSB low; shift 0xAB MSB first; CSB high.
  - Then WAKE_WAIT for WAKE_WAIT cycles; then IDLE.
- IDLE:
  - req_ready = 1 and busy = 0.
  - A request is accepted when req_valid=1 in the same cycle. req_addr is latched with bits [1:0] forced to 0.
  - The next cycle drives CSB low and enters CMD.
- CMD: shift the 8-bit opcode MSB first; opcode = 0x03.
- ADDR: shift the 24-bit address MSB first.
- DATA: sample 32 bits from io1. Each byte is assembled MSB first. Byte k (k=0..3) goes to rsp_data[8k+7:8k].
- After the last DATA bit:
  - CSB goes high and flash_clk stays 0.
  - rsp_valid pulses for exactly one cycle.
  - rsp_data holds its value until the next rsp_valid.
  - Then GAP.
- GAP: CSB stays high for 2*CLK_DIV cycles, then IDLE.
- Requests arriving while not in IDLE are not accepted. req_ready stays 0 and the requester must hold req_valid.
- io0 drives 0 whenever it is not shifting.
- rst asserted mid-transaction:
  - Next cycle, all outputs return to their reset values and CSB rises immediately.
  - No rsp_valid is generated.
  - The wake sequence repeats.

## Timing
- SCLK, mode 0:
  - Low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - io0 changes only on the cycle SCLK goes low, or on the CSB-falling cycle for the first bit.
  - io1 is sampled on the clk edge where SCLK goes high.
- CSB falls one clk cycle after acceptance. The first bit is valid on io0 for CLK_DIV cycles before the first SCLK rise.
- Bit count per read: 8+24+32 = 64 SCLK periods, or 8+24+8+32 = 72 with FAST_READ.
- Accept to rsp_valid latency = 1 + 64*2*CLK_DIV cycles. With CLK_DIV=2 this is 257 cycles. The FAST_READ value follows the same formula with 72.
- Back-to-back throughput: one read per 1 + 64*2*CLK_DIV + 2*CLK_DIV + 1 cycles.
- Wake time from rst release to the first req_ready = 1 + 8*2*CLK_DIV + WAKE_WAIT cycles.

## Configuration
- SPI_FAST_READ_EN defined:
  - Opcode is 0x0B.
  - DUMMY state inserts 8 SCLK periods with io0=0 after ADDR.
  - io1 is ignored during DUMMY.
- SPI_FAST_READ_EN undefined:
  - Opcode is 0x03 and the DUMMY state is not present.
- WAKE handling is identical in both builds.

## Test plan
- Reset release with CLK_DIV=2, WAKE_WAIT=16:
  - io0 carries 0xAB MSB first across 8 SCLK rises with CSB low.
  - CSB then high; req_ready rises at cycle 1+32+16=49.
- Read at req_addr=0x000100, flash model holding bytes 11 22 33 44 there:
  - io0 shows 0x03, then 0x000100.
  - rsp_valid pulses exactly once, 257 cycles after acceptance, with rsp_data=0x44332211.
- req_addr=0x000103: transfer uses address 0x000100 and returns the same 0x44332211.
- Two back-to-back requests (0x0 then 0x4):
  - Second req_ready comes only after the GAP: CSB high for ≥4 cycles between frames.
  - Both responses correct and in order.
- rst asserted at the 20th ADDR bit:
  - Next cycle CSB=1, flash_clk=0, rsp_valid=0, req_ready=0.
  - The 0xAB wake frame is emitted again.
- SPI_FAST_READ_EN build:
  - Opcode 0x0B, then 8 dummy clocks.
  - Same data returned, 289 cycles after acceptance with CLK_DIV=2.
